// File: rtl/tomasulo_pkg.sv
// Shared types and constants for the Tomasulo front end: instruction classes,
// the RV32 opcodes that select them, and the bubble word.
package tomasulo_pkg;

  typedef enum logic [1:0] {
    CLS_OTHER,
    CLS_ARITH,
    CLS_LS
  } instr_class_t;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  // Opcode 0 enables no unit in the core, so an all-zero word is a safe bubble.
  localparam logic [31:0] NOP_BUBBLE = 32'h0000_0000;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/issue_classifier.sv
// Combinational opcode -> instruction class decode; shared with the core's decode.
module issue_classifier
  import tomasulo_pkg::*;
(
  input  logic [6:0]   opcode,
  output instr_class_t cls
);

  always_comb begin
    cls = CLS_OTHER;
    unique case (opcode)
      OPC_LOAD, OPC_STORE: cls = CLS_LS;
      OPC_OP, OPC_OPIMM:   cls = CLS_ARITH;
      default:             cls = CLS_OTHER;
    endcase
  end

endmodule

// File: rtl/instr_issue_queue.sv
// In-order show-ahead issue FIFO feeding the Tomasulo core; the head advances
// when its class is not stalled. Optional counters: ISSUE_QUEUE_STATS_EN.
module instr_issue_queue
  import tomasulo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [XLEN-1:0]            in_instr,
  output logic                       in_ready,
  input  logic                       flush,
  input  logic                       A_stall,
  input  logic                       LS_stall,
  output logic [XLEN-1:0]            instr,
  output logic                       issue_valid,
  output logic                       issue_fire,
  output logic [$clog2(DEPTH):0]     count
`ifdef ISSUE_QUEUE_STATS_EN
  ,
  output logic [31:0]                stat_issued,
  output logic [31:0]                stat_stall_cycles,
  output logic [31:0]                stat_full_cycles
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [XLEN-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            push;
  instr_class_t    cls;

  // Outputs derive only from registered state, so stall logic in the core may
  // be combinational on instr without forming a loop.
  assign in_ready    = (count != FULL);
  assign issue_valid = (count != '0);
  assign instr       = issue_valid ? mem[rd_ptr] : XLEN'(NOP_BUBBLE);
  assign push        = in_valid && in_ready && !flush;

  issue_classifier u_cls (
    .opcode (instr[6:0]),
    .cls    (cls)
  );

  assign issue_fire = issue_valid
                   && !(cls == CLS_ARITH && A_stall)
                   && !(cls == CLS_LS && LS_stall)
                   && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)       wr_ptr <= wr_ptr + AW'(1);
      if (issue_fire) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(issue_fire);
    end
  end

  // Storage carries no reset; stale contents are never visible past count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_instr;
  end

`ifdef ISSUE_QUEUE_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_issued       <= '0;
      stat_stall_cycles <= '0;
      stat_full_cycles  <= '0;
    end else if (flush) begin
      stat_issued       <= '0;
      stat_stall_cycles <= '0;
      stat_full_cycles  <= '0;
    end else begin
      if (issue_fire)                stat_issued       <= sat_inc(stat_issued);
      if (issue_valid && !issue_fire) stat_stall_cycles <= sat_inc(stat_stall_cycles);
      if (count == FULL)             stat_full_cycles  <= sat_inc(stat_full_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_instr_issue_queue.sv
// Directed bench for instr_issue_queue: reset, class stalls, full/wrap,
// back-to-back issue, flush and asynchronous reset.
module tb_instr_issue_queue;

  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
  localparam logic [31:0] ADD = 32'h0020_81B3;
  localparam logic [31:0] LW  = 32'h0000_A283;
  localparam logic [31:0] LUI = 32'h0000_12B7;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic [XLEN-1:0] in_instr;
  logic            in_ready;
  logic            flush;
  logic            A_stall;
  logic            LS_stall;
  logic [XLEN-1:0] instr;
  logic            issue_valid;
  logic            issue_fire;
  logic [$clog2(DEPTH):0] count;
`ifdef ISSUE_QUEUE_STATS_EN
  logic [31:0] stat_issued, stat_stall_cycles, stat_full_cycles;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  instr_issue_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_instr    (in_instr),
    .in_ready    (in_ready),
    .flush       (flush),
    .A_stall     (A_stall),
    .LS_stall    (LS_stall),
    .instr       (instr),
    .issue_valid (issue_valid),
    .issue_fire  (issue_fire),
    .count       (count)
`ifdef ISSUE_QUEUE_STATS_EN
    ,
    .stat_issued       (stat_issued),
    .stat_stall_cycles (stat_stall_cycles),
    .stat_full_cycles  (stat_full_cycles)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Inputs change and outputs are sampled in the low phase, away from posedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] addi(input int k);
    return (32'(k) << 20) | 32'h0000_0013;
  endfunction

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; in_instr = ADD; flush = 1'b0;
    A_stall = 1'b0; LS_stall = 1'b0;
    @(negedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid got %b want 0", issue_valid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", instr); end
    checks++; if (issue_fire !== 1'b0) begin errors++; $display("FAIL reset_issue_fire got %b want 0", issue_fire); end
    tick(); #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
`ifdef ISSUE_QUEUE_STATS_EN
    checks++; if ({stat_issued, stat_stall_cycles, stat_full_cycles} !== 96'h0)
      begin errors++; $display("FAIL reset_stats got %h %h %h want 0", stat_issued, stat_stall_cycles, stat_full_cycles); end
`endif
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    in_valid = 1'b1; in_instr = ADD; A_stall = 1'b0;
    #1;
    checks++; if (issue_valid !== 1'b0 || issue_fire !== 1'b0) begin errors++; $display("FAIL basic_no_bypass got v=%b f=%b want 0 0", issue_valid, issue_fire); end
    tick(); in_valid = 1'b0; #1;
    checks++; if (instr !== ADD) begin errors++; $display("FAIL basic_instr got %h want %h", instr, ADD); end
    checks++; if (issue_fire !== 1'b1) begin errors++; $display("FAIL basic_fire got %b want 1", issue_fire); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL basic_count1 got %0d want 1", count); end
    tick(); #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL basic_count0 got %0d want 0", count); end
    checks++; if (instr !== 32'h0 || issue_valid !== 1'b0) begin errors++; $display("FAIL basic_bubble got %h v=%b want 0 0", instr, issue_valid); end
  endtask

  task automatic test_ls_stall();
    in_valid = 1'b1; in_instr = LW; LS_stall = 1'b1; A_stall = 1'b0;
    tick();
    in_instr = ADD;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (instr !== LW || issue_fire !== 1'b0)
        begin errors++; $display("FAIL ls_hold cyc%0d got %h f=%b want %h f=0", c, instr, issue_fire, LW); end
      tick();
      in_valid = 1'b0;
    end
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL ls_count got %0d want 2", count); end
    LS_stall = 1'b0; #1;
    checks++; if (instr !== LW || issue_fire !== 1'b1) begin errors++; $display("FAIL ls_release got %h f=%b want %h f=1", instr, issue_fire, LW); end
    tick(); #1;
    checks++; if (instr !== ADD || issue_fire !== 1'b1) begin errors++; $display("FAIL ls_next got %h f=%b want %h f=1", instr, issue_fire, ADD); end
    tick(); #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL ls_empty got %0d want 0", count); end
`ifdef ISSUE_QUEUE_STATS_EN
    checks++; if (stat_stall_cycles !== 32'd3) begin errors++; $display("FAIL stat_stall got %0d want 3", stat_stall_cycles); end
    checks++; if (stat_issued !== 32'd3) begin errors++; $display("FAIL stat_issued got %0d want 3", stat_issued); end
`endif
  endtask

  task automatic test_other_class();
    A_stall = 1'b1; LS_stall = 1'b1; in_valid = 1'b1; in_instr = LUI;
    #1;
    checks++; if (issue_fire !== 1'b0) begin errors++; $display("FAIL empty_fire got %b want 0", issue_fire); end
    tick(); in_valid = 1'b0; #1;
    checks++; if (instr !== LUI || issue_fire !== 1'b1) begin errors++; $display("FAIL other_fire got %h f=%b want %h f=1", instr, issue_fire, LUI); end
    tick(); A_stall = 1'b0; LS_stall = 1'b0;
  endtask

  task automatic test_full_wrap();
    int cnt, extra;
    logic acc;
    A_stall = 1'b1; exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in_instr = addi(i + 1); exp_q.push_back(addi(i + 1));
      tick();
    end
    in_instr = 32'hDEAD_0013; #1;
    checks++; if (count !== 4'd8 || in_ready !== 1'b0) begin errors++; $display("FAIL full_state got c=%0d r=%b want 8 0", count, in_ready); end
    tick(); #1;
    checks++; if (count !== 4'd8 || instr !== addi(1)) begin errors++; $display("FAIL full_drop got c=%0d %h want 8 %h", count, instr, addi(1)); end
    A_stall = 1'b0; cnt = DEPTH; extra = 0;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      acc = 1'b0;
      if (extra < 4) begin
        in_valid = 1'b1; in_instr = addi(100 + extra); acc = (cnt != DEPTH);
      end else in_valid = 1'b0;
      #1;
      checks++; if (issue_fire !== 1'b1 || instr !== exp_q[0] || count !== 4'(cnt))
        begin errors++; $display("FAIL drain cyc%0d got %h f=%b c=%0d want %h f=1 c=%0d", c, instr, issue_fire, count, exp_q[0], cnt); end
      void'(exp_q.pop_front());
      if (acc) begin exp_q.push_back(addi(100 + extra)); extra++; end
      cnt = cnt + int'(acc) - 1;
      tick();
    end
    in_valid = 1'b0;
    checks++; if (exp_q.size() != 0 || extra != 4) begin errors++; $display("FAIL drain_done got left=%0d pushed=%0d want 0 4", exp_q.size(), extra); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    A_stall = 1'b1; exp_q.delete();
    for (int i = 0; i < DEPTH - 1; i++) begin
      in_valid = 1'b1; in_instr = addi(200 + i); exp_q.push_back(addi(200 + i));
      tick();
    end
    A_stall = 1'b0;
    for (int c = 0; c < 10; c++) begin
      v = (c % 2 == 0) ? ((32'(c) << 12) | 32'h37) : addi(300 + c);
      in_valid = 1'b1; in_instr = v; #1;
      checks++; if (issue_fire !== 1'b1 || instr !== exp_q[0] || count !== 4'd7)
        begin errors++; $display("FAIL b2b cyc%0d got %h f=%b c=%0d want %h f=1 c=7", c, instr, issue_fire, count, exp_q[0]); end
      void'(exp_q.pop_front());
      exp_q.push_back(v);
      tick();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      #1;
      checks++; if (issue_fire !== 1'b1 || instr !== exp_q[0])
        begin errors++; $display("FAIL b2b_drain cyc%0d got %h f=%b want %h f=1", c, instr, issue_fire, exp_q[0]); end
      void'(exp_q.pop_front());
      tick();
    end
    #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL b2b_empty got %0d want 0", count); end
  endtask

  task automatic test_flush();
    A_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_instr = addi(400 + i);
      tick();
    end
    A_stall = 1'b0; flush = 1'b1; in_instr = 32'h0BAD_0033; #1;
    checks++; if (count !== 4'd5 || issue_fire !== 1'b0) begin errors++; $display("FAIL flush_cycle got c=%0d f=%b want 5 0", count, issue_fire); end
    tick(); flush = 1'b0; in_valid = 1'b0; #1;
    checks++; if (count !== 4'd0 || issue_valid !== 1'b0 || instr !== 32'h0)
      begin errors++; $display("FAIL flush_after got c=%0d v=%b %h want 0 0 0", count, issue_valid, instr); end
`ifdef ISSUE_QUEUE_STATS_EN
    checks++; if (stat_issued !== 32'd0 || stat_full_cycles !== 32'd0) begin errors++; $display("FAIL flush_stats got %0d %0d want 0 0", stat_issued, stat_full_cycles); end
`endif
    tick(); #1;
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL flush_beat got v=%b %h want 0", issue_valid, instr); end
  endtask

  task automatic test_async_reset();
    A_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_instr = addi(500 + i);
      tick();
    end
    in_valid = 1'b0; #1;
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL areset_pre got %0d want 3", count); end
    #2 reset = 1'b0;
    #1;
    checks++; if (count !== 4'd0 || issue_valid !== 1'b0 || instr !== 32'h0 || in_ready !== 1'b1 || issue_fire !== 1'b0)
      begin errors++; $display("FAIL areset_now got c=%0d v=%b %h r=%b f=%b want 0 0 0 1 0", count, issue_valid, instr, in_ready, issue_fire); end
    @(negedge clk); reset = 1'b1; A_stall = 1'b0;
    in_valid = 1'b1; in_instr = ADD;
    tick(); in_valid = 1'b0; #1;
    checks++; if (instr !== ADD || issue_fire !== 1'b1 || count !== 4'd1)
      begin errors++; $display("FAIL areset_resume got %h f=%b c=%0d want %h 1 1", instr, issue_fire, count, ADD); end
    tick(); #1;
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL areset_stale got v=%b %h want 0", issue_valid, instr); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ls_stall();
    test_other_class();
    test_full_wrap();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
